ram_wait_ctrl: RTL and testbench
================================

Name: ram_wait_ctrl

Overview:
- Word-organised on-chip RAM with a programmable wait-state controller.
- Sits directly downstream of the request/memory-control stage and consumes its RAM bus (Ren, Wen, ramaddr, ramstore).
- Returns ramload and the busy_o stall signal that the upstream arbiter waits on.
- Models multi-cycle memory latency so instruction and data arbitration is exercised under realistic stalls.

Parameters:
- ADDR_W, 10: word-index width; depth = 2**ADDR_W words of 32 bits.
- WAIT_STATES, 2: extra busy cycles per access; legal range 0..15.
- OOR_DATA, 32'hBAD1BAD1: read data returned for out-of-range addresses.

Ports:
- CLK  in  1  rising-edge clock.
- nRST  in  1  asynchronous reset, active-HIGH: 1 = reset asserted. The port name is kept for bus compatibility.
- Ren  in  1  read request, level, held by the master until completion.
- Wen  in  1  write request, level; has priority over Ren.
- ramaddr  in  32  byte address; word index = ramaddr[ADDR_W+1:2]; bits [1:0] ignored.
- ramstore  in  32  write data.
- ramload  out  32  read data, valid in the completion cycle.
- busy_o  out  1  1 = access in progress; the master must hold its request.
- err_o  out  1  one-cycle pulse in the completion cycle of an erroneous access.

Behaviour:
- Reset (nRST=1, asynchronous):
  - state = IDLE; busy_o, err_o, ramload, counter = 0.
  - RAM contents are not cleared.
  - Reset mid-access aborts the access; no write is committed.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - busy_o = Ren|Wen, combinational.
  - On Ren|Wen, latch op (write if Wen), address and ramstore.
  - Next state is ACCESS if WAIT_STATES==0; otherwise WAIT with cnt = WAIT_STATES-1.
  - With no request, busy_o = 0 and ramload holds its last value.
- WAIT:
  - busy_o = 1.
  - If cnt==0, go to ACCESS; else decrement cnt.
- Abort rule (WAIT only):
  - Abort if the live request no longer matches the latch: Ren|Wen dropped, op changed, word index changed, or, for writes, ramstore changed.
  - On Ren|Wen dropped: go to IDLE, no side effect.
  - Otherwise: re-latch the new request and restart the count as if from IDLE; busy_o stays 1.
- Entry to ACCESS (same clock edge): ramload <= mem[idx] for reads, or OOR_DATA if out of range.
- ACCESS:
  - busy_o = 0; ramload valid.
  - A write commits mem[idx] <= data on the edge ending this cycle.
  - ACCESS always completes; the next state is IDLE.
- Latency: a request first seen in IDLE at cycle 0 gives busy_o = 1 for cycles 0..WAIT_STATES and completion at cycle WAIT_STATES+1.
- Throughput: back-to-back requests cost WAIT_STATES+2 cycles each, because the IDLE cycle re-arbitrates.
- Writes: ramload is unchanged by a write.
- Read-after-write to the same word returns the new data.
- Out of range means ramaddr[31:ADDR_W+2] != 0:
  - Reads return OOR_DATA.
  - Writes are dropped.
  - err_o = 1 in ACCESS.
- Ren & Wen both high: treated as a write and err_o = 1 in ACCESS.
- Requests arriving during ACCESS are ignored until the following IDLE cycle.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x40 with WAIT_STATES=2: busy_o = 1 in cycles 0-2, 0 in cycle 3; deassert. Then read 0x40: ramload = 32'hDEADBEEF in cycle 3, busy_o = 0, err_o = 0.
- WAIT_STATES=0: read 0x44 (preloaded 32'h12345678) -> busy_o = 1 in cycle 0, ramload = 32'h12345678 with busy_o = 0 in cycle 1. Repeat with ramaddr=0x47: same word returned.
- Abort: read 0x40 starts; at cycle 1 ramaddr changes to 0x80 (holding 32'hA5A5A5A5) -> busy_o stays 1 for cycles 1-3, completion at cycle 4 with ramload = 32'hA5A5A5A5; word 0x40 is not returned.
- Out of range with ADDR_W=10: read 0x0000_1000 -> ramload = 32'hBAD1BAD1 and err_o pulses once. A write to the same address leaves all in-range words unchanged.
- Ren=Wen=1 to 0x10 with data 32'h0F0F0F0F -> err_o pulses. A subsequent read of 0x10 returns 32'h0F0F0F0F.
- Assert nRST during WAIT of a write to 0x20 (old value 32'h1) -> busy_o = 0 immediately. After release, a read of 0x20 returns 32'h1.

Source files
------------

// File: rtl/ram_wait_ctrl.sv
// ram_wait_ctrl: word-organised 32-bit on-chip RAM behind a wait-state controller.
// Each access holds busy_o high for WAIT_STATES+1 cycles and completes in the
// following cycle (the ACCESS cycle), where read data and err_o are presented.
//
// Ports:
//   CLK       rising-edge clock
//   nRST      asynchronous reset, active-HIGH despite the name (bus-compatible name)
//   Ren       read request, level, held until completion
//   Wen       write request, level, wins over Ren
//   ramaddr   byte address; word index = ramaddr[ADDR_W+1:2]
//   ramstore  write data
//   ramload   read data, valid in the completion cycle, held otherwise
//   busy_o    access in progress, master must hold its request
//   err_o     one-cycle pulse on completion of an out-of-range or Ren&Wen access
module ram_wait_ctrl #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] OOR_DATA    = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        Ren,
    input  logic        Wen,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic        busy_o,
    output logic        err_o
);
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                oor_q, oor_d;
    logic                both_q, both_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         ramload_q, ramload_d;
    logic [31:0]         mem [DEPTH];

    logic                req;
    logic                start;
    logic                mismatch;
    logic [ADDR_W-1:0]   live_idx;
    logic                live_oor;

    assign req      = Ren | Wen;
    assign live_idx = ramaddr[ADDR_W+1:2];
    assign live_oor = |(ramaddr >> (ADDR_W + 2));

    // A request that moved while waiting must not complete with stale latched
    // values. A change in range-ness counts as an address change as well.
    assign mismatch = (Wen != wr_q) || (live_idx != idx_q) || (live_oor != oor_q) ||
                      (Wen && (ramstore != data_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        oor_d     = oor_q;
        both_d    = both_q;
        data_d    = data_q;
        ramload_d = ramload_q;
        busy_o    = 1'b0;
        err_o     = 1'b0;
        start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_o = req;
                start  = req;
            end
            ST_WAIT: begin
                busy_o = 1'b1;
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (mismatch) begin
                    start = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                err_o   = oor_q | both_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Fresh latch, used both from IDLE and when a waiting request is replaced.
        if (start) begin
            wr_d   = Wen;
            idx_d  = live_idx;
            oor_d  = live_oor;
            both_d = Ren & Wen;
            data_d = ramstore;
            if (WAIT_STATES == 0) begin
                state_d = ST_ACCESS;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = CNT_INIT;
            end
        end

        // Read data is captured on the edge that enters ACCESS, using the
        // request values that the edge itself latches (matters for zero waits).
        if ((state_d == ST_ACCESS) && (state_q != ST_ACCESS) && !wr_d) begin
            ramload_d = oor_d ? OOR_DATA : mem[idx_d];
        end

        // Reset forces the stall low even while a master still holds a request.
        if (nRST) begin
            busy_o = 1'b0;
            err_o  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            oor_q     <= 1'b0;
            both_q    <= 1'b0;
            data_q    <= 32'd0;
            ramload_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            idx_q     <= idx_d;
            oor_q     <= oor_d;
            both_q    <= both_d;
            data_q    <= data_d;
            ramload_q <= ramload_d;
        end
    end

    // Storage is never reset; a write only commits at the end of ACCESS and
    // is suppressed while reset is held.
    always_ff @(posedge CLK) begin
        if (!nRST && (state_q == ST_ACCESS) && wr_q && !oor_q) begin
            mem[idx_q] <= data_q;
        end
    end

    assign ramload = ramload_q;

endmodule

// File: tb/tb_ram_wait_ctrl.sv
module tb_ram_wait_ctrl;
    localparam logic [31:0] OOR = 32'hBAD1BAD1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren, wen, sel;
    logic [31:0] addr, wdata;
    logic [31:0] load_a, load_b;
    logic        busy_a, busy_b, err_a, err_b;
    logic        busy, err;
    logic [31:0] load;
    int          checks = 0;
    int          errors = 0;

    // Reference state: per-DUT word memory and last returned read data.
    logic [31:0] mm   [2][1024];
    logic [31:0] last [2];

    always #5 clk = ~clk;

    ram_wait_ctrl #(.ADDR_W(10), .WAIT_STATES(2), .OOR_DATA(OOR)) dut_a (
        .CLK(clk), .nRST(rst), .Ren(ren & !sel), .Wen(wen & !sel), .ramaddr(addr),
        .ramstore(wdata), .ramload(load_a), .busy_o(busy_a), .err_o(err_a));

    ram_wait_ctrl #(.ADDR_W(10), .WAIT_STATES(0), .OOR_DATA(OOR)) dut_b (
        .CLK(clk), .nRST(rst), .Ren(ren & sel), .Wen(wen & sel), .ramaddr(addr),
        .ramstore(wdata), .ramload(load_b), .busy_o(busy_b), .err_o(err_b));

    assign busy = sel ? busy_b : busy_a;
    assign err  = sel ? err_b  : err_a;
    assign load = sel ? load_b : load_a;

    function automatic int ws();
        return sel ? 0 : 2;
    endfunction

    // Transaction-level model: what one completed access should return.
    task automatic model_access(input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] eld,
                                output logic [15:0] ebt, output logic [15:0] eet);
        int s;
        bit oor;
        int idx;
        s   = sel ? 1 : 0;
        oor = (a[31:12] != 20'd0);
        idx = int'(a[11:2]);
        if (w) begin
            if (!oor) mm[s][idx] = d;
        end else begin
            last[s] = oor ? OOR : mm[s][idx];
        end
        eld = last[s];
        ebt = (16'd1 << (ws() + 1)) - 16'd1;
        eet = (oor || (r && w)) ? (16'd1 << (ws() + 1)) : 16'd0;
    endtask

    // Drives one held request and records busy/err per cycle (cycles 0..WS+2).
    task automatic drive_access(input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] d, output logic [15:0] bt,
                                output logic [15:0] et, output logic [31:0] ld);
        int n;
        n  = ws();
        bt = '0;
        et = '0;
        ld = '0;
        @(negedge clk);
        ren = r; wen = w; addr = a; wdata = d;
        #1;
        bt[0] = busy; et[0] = err;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            bt[k] = busy; et[k] = err;
            if (k == n + 1) begin
                ld  = load;
                ren = 1'b0; wen = 1'b0;
            end
        end
        @(negedge clk);
        bt[n+2] = busy; et[n+2] = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; ren = 1'b0; wen = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset busy: got %b%b want 00", busy_a, busy_b); end
        checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin errors++; $display("FAIL reset err: got %b%b want 00", err_a, err_b); end
        checks++; if (load_a !== 32'd0 || load_b !== 32'd0) begin errors++; $display("FAIL reset ramload: got %h/%h want 0", load_a, load_b); end
        rst = 1'b0;
        last[0] = '0; last[1] = '0;
    endtask

    // Runs a small table of accesses on the selected DUT, comparing with the model.
    task automatic test_write_read();
        logic [31:0] ta [4];
        logic [31:0] td [4];
        bit          tw [4];
        logic [15:0] bt, et, ebt, eet;
        logic [31:0] ld, eld;
        ta = '{32'h40, 32'h40, 32'h44, 32'h47};
        td = '{32'hDEADBEEF, 32'h0, 32'h12345678, 32'h0};
        tw = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int i = (s == 0) ? 0 : 1; i < 4; i++) begin
                if (s == 0 && i > 1) break;
                drive_access(!tw[i], tw[i], ta[i], td[i], bt, et, ld);
                model_access(!tw[i], tw[i], ta[i], td[i], eld, ebt, eet);
                checks++; if (bt !== ebt) begin errors++; $display("FAIL basic busy dut%0d op%0d: got %b want %b", s, i, bt, ebt); end
                checks++; if (et !== eet) begin errors++; $display("FAIL basic err dut%0d op%0d: got %b want %b", s, i, et, eet); end
                checks++; if (ld !== eld) begin errors++; $display("FAIL basic ramload dut%0d op%0d: got %h want %h", s, i, ld, eld); end
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_abort();
        logic [15:0] bt, et, ebt, eet;
        logic [31:0] ld, eld;
        logic [4:0]  b;
        sel = 1'b0;
        drive_access(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, bt, et, ld);
        model_access(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, eld, ebt, eet);
        // Address moves from 0x40 to 0x80 one cycle into the wait.
        @(negedge clk); ren = 1'b1; addr = 32'h40; #1; b[0] = busy_a;
        @(negedge clk); b[1] = busy_a; addr = 32'h80;
        @(negedge clk); b[2] = busy_a;
        @(negedge clk); b[3] = busy_a;
        @(negedge clk); b[4] = busy_a; ld = load_a; ren = 1'b0;
        last[0] = mm[0][32];
        checks++; if (b !== 5'b01111) begin errors++; $display("FAIL abort_addr busy: got %b want 01111", b); end
        checks++; if (ld !== 32'hA5A5A5A5) begin errors++; $display("FAIL abort_addr ramload: got %h want a5a5a5a5", ld); end
        // Write dropped mid-wait: back to idle, nothing committed.
        @(negedge clk); wen = 1'b1; addr = 32'h40; wdata = 32'h11111111; #1; b[0] = busy_a;
        @(negedge clk); b[1] = busy_a; wen = 1'b0;
        @(negedge clk); b[2] = busy_a;
        checks++; if (b[2:0] !== 3'b011) begin errors++; $display("FAIL abort_drop busy: got %b want 011", b[2:0]); end
        // Write data changes mid-wait: the new data is what lands.
        @(negedge clk); wen = 1'b1; wdata = 32'h22222222; #1; b[0] = busy_a;
        @(negedge clk); b[1] = busy_a; wdata = 32'h33333333;
        @(negedge clk); b[2] = busy_a;
        @(negedge clk); b[3] = busy_a;
        @(negedge clk); b[4] = busy_a; wen = 1'b0;
        mm[0][16] = 32'h33333333;
        checks++; if (b !== 5'b01111) begin errors++; $display("FAIL abort_data busy: got %b want 01111", b); end
        drive_access(1'b1, 1'b0, 32'h40, 32'h0, bt, et, ld);
        model_access(1'b1, 1'b0, 32'h40, 32'h0, eld, ebt, eet);
        checks++; if (ld !== eld) begin errors++; $display("FAIL abort_readback ramload: got %h want %h", ld, eld); end
    endtask

    task automatic test_oor_and_both();
        logic [31:0] ta [6];
        logic [31:0] td [6];
        bit          tr [6];
        bit          tw [6];
        logic [15:0] bt, et, ebt, eet;
        logic [31:0] ld, eld;
        ta = '{32'h0, 32'h1000, 32'h1000, 32'h0, 32'h10, 32'h10};
        td = '{32'h0000C0DE, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0F0F0F0F, 32'h0};
        tr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_access(tr[i], tw[i], ta[i], td[i], bt, et, ld);
            model_access(tr[i], tw[i], ta[i], td[i], eld, ebt, eet);
            checks++; if (bt !== ebt) begin errors++; $display("FAIL oor_both busy op%0d: got %b want %b", i, bt, ebt); end
            checks++; if (et !== eet) begin errors++; $display("FAIL oor_both err op%0d: got %b want %b", i, et, eet); end
            checks++; if (ld !== eld) begin errors++; $display("FAIL oor_both ramload op%0d: got %h want %h", i, ld, eld); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] bt, et, ebt, eet;
        logic [31:0] ld, eld;
        sel = 1'b0;
        drive_access(1'b0, 1'b1, 32'h20, 32'h1, bt, et, ld);
        model_access(1'b0, 1'b1, 32'h20, 32'h1, eld, ebt, eet);
        @(negedge clk); wen = 1'b1; addr = 32'h20; wdata = 32'h99999999;
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy_a); end
        checks++; if (load_a !== 32'd0) begin errors++; $display("FAIL reset_mid ramload: got %h want 0", load_a); end
        @(negedge clk); wen = 1'b0;
        @(negedge clk); rst = 1'b0;
        last[0] = '0; last[1] = '0;
        drive_access(1'b1, 1'b0, 32'h20, 32'h0, bt, et, ld);
        model_access(1'b1, 1'b0, 32'h20, 32'h0, eld, ebt, eet);
        checks++; if (ld !== 32'h1) begin errors++; $display("FAIL reset_mid readback: got %h want 00000001", ld); end
    endtask

    task automatic test_back_to_back();
        int          w;
        logic        eb;
        logic [31:0] exp;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            w   = ws();
            exp = s ? mm[1][17] : mm[0][16];
            @(negedge clk); ren = 1'b1; addr = s ? 32'h44 : 32'h40; #1;
            for (int c = 0; c < 2 * (w + 2); c++) begin
                if (c > 0) @(negedge clk);
                eb = ((c % (w + 2)) != (w + 1));
                checks++; if (busy !== eb) begin errors++; $display("FAIL b2b busy dut%0d cyc%0d: got %b want %b", s, c, busy, eb); end
                if (!eb) begin
                    checks++; if (load !== exp) begin errors++; $display("FAIL b2b ramload dut%0d cyc%0d: got %h want %h", s, c, load, exp); end
                end
            end
            ren = 1'b0;
            last[s] = exp;
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] bt, et, ebt, eet;
        logic [31:0] ld, eld, a, d;
        bit          r, w;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int i = 0; i < 8; i++) begin
                d = $urandom;
                drive_access(1'b0, 1'b1, 32'(i * 4), d, bt, et, ld);
                model_access(1'b0, 1'b1, 32'(i * 4), d, eld, ebt, eet);
            end
        end
        for (int n = 0; n < 40; n++) begin
            sel = ($urandom_range(0, 1) == 1);
            a   = {20'd0, 7'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 32'hFFFFF));
            d = $urandom;
            w = ($urandom_range(0, 1) == 1);
            r = !w || ($urandom_range(0, 5) == 0);
            drive_access(r, w, a, d, bt, et, ld);
            model_access(r, w, a, d, eld, ebt, eet);
            checks++; if (bt !== ebt) begin errors++; $display("FAIL random busy #%0d: got %b want %b", n, bt, ebt); end
            checks++; if (et !== eet) begin errors++; $display("FAIL random err #%0d: got %b want %b", n, et, eet); end
            checks++; if (ld !== eld) begin errors++; $display("FAIL random ramload #%0d addr %h: got %h want %h", n, a, ld, eld); end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_abort();
        test_oor_and_both();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
